// File: rtl/mpq_host_driver.sv
// rtl/mpq_host_driver.sv - host-side driver that streams data, issues commands and captures results for the queue engine
module mpq_host_driver #(
  parameter int CMD_AW  = 5,
  parameter int DATA_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic              prog_sel,
  input  logic [7:0]        prog_addr,
  input  logic [18:0]       prog_wdata,
  input  logic [8:0]        data_len,
  input  logic [CMD_AW:0]   cmd_len,
  input  logic              start,
  output logic              data_valid,
  output logic [7:0]        data,
  output logic              cmd_valid,
  output logic [2:0]        cmd,
  output logic [7:0]        index,
  output logic [7:0]        value,
  input  logic              busy,
  input  logic              RAM_valid,
  input  logic [7:0]        RAM_A,
  input  logic [7:0]        RAM_D,
  input  logic              done,
  input  logic [7:0]        rd_addr,
  output logic [7:0]        rd_data,
  output logic [8:0]        res_count,
  output logic              finished
);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, GUARD, WAIT, CAPTURE, FINISH} state_t;

  localparam logic [CMD_AW:0] CMD_ONE = 1;

  state_t            state;
  logic [18:0]       cmem [2**CMD_AW];
  logic [7:0]        dmem [2**DATA_AW];
  logic [7:0]        rmem [2**DATA_AW];
  logic [8:0]        dlen;
  logic [8:0]        ptr;
  logic [CMD_AW:0]   clen;
  logic [CMD_AW:0]   cptr;
  logic [CMD_AW:0]   cptr_inc;
  logic              prog_ok;
  logic              is_wb;

  assign prog_ok  = (state == IDLE) || (state == FINISH);
  assign is_wb    = (cmd == 3'd4) || (cmd == 3'd6) || (cmd == 3'd7);
  assign cptr_inc = cptr + CMD_ONE;
  assign rd_data  = rmem[rd_addr[DATA_AW-1:0]];

  // Memories carry no reset so programs and results survive rst.
  always_ff @(posedge clk) begin
    if (prog_we && prog_ok) begin
      if (prog_sel)
        cmem[prog_addr[CMD_AW-1:0]] <= prog_wdata;
      else
        dmem[prog_addr[DATA_AW-1:0]] <= prog_wdata[7:0];
    end
    if (RAM_valid)
      rmem[RAM_A[DATA_AW-1:0]] <= RAM_D;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      data_valid <= 1'b0;
      data       <= '0;
      cmd_valid  <= 1'b0;
      cmd        <= '0;
      index      <= '0;
      value      <= '0;
      finished   <= 1'b0;
      res_count  <= '0;
      ptr        <= '0;
      cptr       <= '0;
      dlen       <= '0;
      clen       <= '0;
    end else begin
      if (RAM_valid && res_count != 9'd256)
        res_count <= res_count + 9'd1;

      case (state)
        IDLE, FINISH: begin
          if (start) begin
            dlen      <= data_len;
            clen      <= cmd_len;
            res_count <= '0;
            finished  <= 1'b0;
            cptr      <= '0;
            if (data_len != 9'd0) begin
              state      <= LOAD;
              data_valid <= 1'b1;
              data       <= dmem[0];
              ptr        <= 9'd1;
            end else if (cmd_len != '0) begin
              // A free engine gets the first command with no extra cycle.
              state                <= ISSUE;
              ptr                  <= '0;
              cmd_valid            <= !busy;
              {cmd, index, value}  <= cmem[0];
            end else begin
              state    <= FINISH;
              finished <= 1'b1;
              ptr      <= '0;
            end
          end
        end
        LOAD: begin
          if (ptr == dlen) begin
            data_valid <= 1'b0;
            if (clen != '0) begin
              state               <= ISSUE;
              cmd_valid           <= !busy;
              {cmd, index, value} <= cmem[cptr[CMD_AW-1:0]];
            end else begin
              state    <= FINISH;
              finished <= 1'b1;
            end
          end else begin
            data <= dmem[ptr[DATA_AW-1:0]];
            ptr  <= ptr + 9'd1;
          end
        end
        ISSUE: begin
          if (cmd_valid) begin
            cmd_valid <= 1'b0;
            state     <= GUARD;
          end else if (!busy) begin
            cmd_valid           <= 1'b1;
            {cmd, index, value} <= cmem[cptr[CMD_AW-1:0]];
          end
        end
        GUARD: state <= is_wb ? CAPTURE : WAIT;
        WAIT: begin
          if (!busy) begin
            if (cptr_inc < clen) begin
              // busy is already low here, so the next command goes out on entry.
              cptr                <= cptr_inc;
              state               <= ISSUE;
              cmd_valid           <= 1'b1;
              {cmd, index, value} <= cmem[cptr_inc[CMD_AW-1:0]];
            end else begin
              state    <= FINISH;
              finished <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (done) begin
            state    <= FINISH;
            finished <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpq_host_driver.sv
// tb/tb_mpq_host_driver.sv - directed self-checking bench for mpq_host_driver
module tb_mpq_host_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we, prog_sel;
  logic [7:0]  prog_addr;
  logic [18:0] prog_wdata;
  logic [8:0]  data_len;
  logic [5:0]  cmd_len;
  logic        start;
  logic        data_valid;
  logic [7:0]  data;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [7:0]  index, value;
  logic        busy;
  logic        RAM_valid;
  logic [7:0]  RAM_A, RAM_D;
  logic        done;
  logic [7:0]  rd_addr, rd_data;
  logic [8:0]  res_count;
  logic        finished;

  int          n_checks = 0;
  int          n_err = 0;
  int          bcnt;
  bit          cv;
  logic [7:0]  dbuf [0:15];
  logic [2:0]  ccmd [0:7];
  logic [7:0]  cidx [0:7];
  logic [7:0]  cval [0:7];
  int          ccyc [0:7];
  bit          bhist [0:127];
  int          nd, nc, dv_first, dv_last, fin_cyc, first_free;
  logic [7:0]  rdat [0:3];
  logic [7:0]  exp_d [0:3];

  always #5 clk = ~clk;

  mpq_host_driver #(.CMD_AW(5), .DATA_AW(8)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_sel(prog_sel),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .data_len(data_len),
    .cmd_len(cmd_len), .start(start), .data_valid(data_valid), .data(data),
    .cmd_valid(cmd_valid), .cmd(cmd), .index(index), .value(value),
    .busy(busy), .RAM_valid(RAM_valid), .RAM_A(RAM_A), .RAM_D(RAM_D),
    .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .res_count(res_count), .finished(finished)
  );

  // Engine model: busy for the three cycles following each cmd_valid cycle.
  initial begin
    busy = 1'b0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      cv = cmd_valid;
      @(posedge clk);
      #1;
      if (cv) bcnt = 3;
      else if (bcnt > 0) bcnt = bcnt - 1;
      busy = (bcnt != 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic prog(input logic sel, input logic [7:0] a, input logic [18:0] w);
    @(negedge clk);
    prog_we = 1'b1; prog_sel = sel; prog_addr = a; prog_wdata = w;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic go(input logic [8:0] dl, input logic [5:0] cl);
    @(negedge clk);
    data_len = dl; cmd_len = cl; start = 1'b1;
  endtask

  // Cycle 1 is the first cycle after the start edge.
  task automatic run(input int max_cyc, input bit respond, input int wr_cyc);
    int  k, wb_cyc;
    bit  wb;
    nd = 0; nc = 0; dv_first = -1; dv_last = -1; fin_cyc = -1;
    k = 0; wb = 0; wb_cyc = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c < 128) bhist[c] = busy;
      if (data_valid) begin
        if (nd < 16) dbuf[nd] = data;
        nd++;
        if (dv_first < 0) dv_first = c;
        dv_last = c;
      end
      if (cmd_valid) begin
        if (nc < 8) begin
          ccmd[nc] = cmd; cidx[nc] = index; cval[nc] = value; ccyc[nc] = c;
        end
        nc++;
        if (cmd == 3'd4 || cmd == 3'd6 || cmd == 3'd7) begin
          wb = 1; wb_cyc = c;
        end
      end
      RAM_valid = 1'b0; done = 1'b0; prog_we = 1'b0;
      if (respond && wb && c >= wb_cyc + 2 && k < 4) begin
        RAM_valid = 1'b1; RAM_A = k[7:0]; RAM_D = rdat[k]; done = (k == 3);
        k++;
      end
      if (c == wr_cyc) begin
        prog_we = 1'b1; prog_sel = 1'b1; prog_addr = 8'd1;
        prog_wdata = {3'd2, 8'h55, 8'h66};
      end
      if (finished) begin
        fin_cyc = c;
        break;
      end
    end
    if (fin_cyc < 0) check("finish_timeout", finished, 1);
  endtask

  initial begin
    rdat[0] = 8'd9; rdat[1] = 8'd7; rdat[2] = 8'd5; rdat[3] = 8'd2;
    exp_d[0] = 8'd5; exp_d[1] = 8'd9; exp_d[2] = 8'd2; exp_d[3] = 8'd7;
    rst = 1'b1; prog_we = 1'b0; prog_sel = 1'b0; prog_addr = '0; prog_wdata = '0;
    data_len = '0; cmd_len = '0; start = 1'b0; RAM_valid = 1'b0; RAM_A = '0;
    RAM_D = '0; done = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_data_valid", data_valid, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_finished", finished, 0);
    check("rst_res_count", res_count, 0);
    rst = 1'b0;

    // Data-only stream
    for (int i = 0; i < 4; i++) prog(1'b0, i[7:0], {11'd0, exp_d[i]});
    go(9'd4, 6'd0);
    run(40, 0, 0);
    check("t1_beats", nd, 4);
    for (int i = 0; i < 4; i++) check("t1_data", dbuf[i], exp_d[i]);
    check("t1_dv_first", dv_first, 1);
    check("t1_dv_last", dv_last, 4);
    check("t1_no_cmd", nc, 0);
    check("t1_fin_cyc", fin_cyc, 5);

    // Two commands, second is write-back with responder
    prog(1'b1, 8'd0, {3'd0, 8'h00, 8'h00});
    prog(1'b1, 8'd1, {3'd4, 8'h3C, 8'hA5});
    go(9'd0, 6'd2);
    run(60, 1, 0);
    check("t2_pulses", nc, 2);
    check("t2_cmd0", ccmd[0], 0);
    check("t2_cyc0", ccyc[0], 1);
    check("t2_cmd1", ccmd[1], 4);
    check("t2_idx1", cidx[1], 8'h3C);
    check("t2_val1", cval[1], 8'hA5);
    check("t2_cyc1", ccyc[1], 6);
    first_free = -1;
    for (int c = ccyc[0] + 2; c < 64; c++)
      if (first_free < 0 && !bhist[c]) first_free = c;
    check("t2_not_early", ccyc[1] >= first_free, 1);
    check("t3_finished", finished, 1);
    check("t3_res_count", res_count, 4);
    for (int i = 0; i < 4; i++) begin
      rd_addr = i[7:0];
      #1;
      check("t3_rd_data", rd_data, rdat[i]);
    end

    // Write-back first: the following entry is never issued
    prog(1'b1, 8'd0, {3'd4, 8'h00, 8'h00});
    prog(1'b1, 8'd1, {3'd1, 8'h00, 8'h00});
    go(9'd0, 6'd2);
    run(60, 1, 0);
    check("t4_pulses", nc, 1);
    check("t4_cmd0", ccmd[0], 4);
    check("t4_res_count", res_count, 4);

    // Program write during WAIT is ignored
    prog(1'b1, 8'd0, {3'd0, 8'h11, 8'h22});
    prog(1'b1, 8'd1, {3'd1, 8'h33, 8'h44});
    go(9'd0, 6'd2);
    run(60, 0, 3);
    check("t6_pulses", nc, 2);
    check("t6_idx0", cidx[0], 8'h11);
    check("t6_cmd1", ccmd[1], 1);
    check("t6_idx1", cidx[1], 8'h33);
    check("t6_val1", cval[1], 8'h44);
    check("t6_fin_cyc", fin_cyc, 11);

    // Reset mid-LOAD, reprogram, restart from ptr 0
    go(9'd4, 6'd0);
    @(negedge clk); start = 1'b0;
    check("t5_loading", data_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_dv", data_valid, 0);
    check("t5_rst_res", res_count, 0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_abandoned", data_valid, 0);
    prog(1'b0, 8'd0, {11'd0, 8'h66});
    go(9'd2, 6'd0);
    run(30, 0, 0);
    check("t5_beats", nd, 2);
    check("t5_d0", dbuf[0], 8'h66);
    check("t5_d1", dbuf[1], 8'd9);
    check("t5_dv_first", dv_first, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mpq_host_driver.md
MPQ_HOST_DRIVER -- requirements
Module: mpq_host_driver

Interface
REQ-001 SHALL have parameter CMD_AW, default 5, meaning command-program address width (32 entries).
REQ-002 SHALL have parameter DATA_AW, default 8, meaning data-program and result-memory address width (256 bytes).
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port prog_we, input, 1, program-memory write strobe.
REQ-006 SHALL have port prog_sel, input, 1, program-memory select: 0 = data memory, 1 = command memory.
REQ-007 SHALL have port prog_addr, input, 8, program-memory write address.
REQ-008 SHALL have port prog_wdata, input, 19, write data: data[7:0] when prog_sel=0; {cmd[18:16], index[15:8], value[7:0]} when prog_sel=1.
REQ-009 SHALL have port data_len, input, 9, number of data bytes to stream (0..256), sampled on start.
REQ-010 SHALL have port cmd_len, input, CMD_AW+1, number of commands to issue, sampled on start.
REQ-011 SHALL have port start, input, 1, one-cycle run request.
REQ-012 SHALL have ports data_valid (output, 1) and data (output, 8), the byte stream to the queue engine.
REQ-013 SHALL have ports cmd_valid (output, 1), cmd (output, 3), index (output, 8) and value (output, 8), the command to the queue engine.
REQ-014 SHALL have port busy, input, 1, queue-engine busy flag.
REQ-015 SHALL have ports RAM_valid (input, 1), RAM_A (input, 8) and RAM_D (input, 8), the result write-back from the queue engine.
REQ-016 SHALL have port done, input, 1, queue-engine write-back complete flag.
REQ-017 SHALL have ports rd_addr (input, 8) and rd_data (output, 8), a combinational read of the result memory.
REQ-018 SHALL have port res_count, output, 9, number of RAM_valid beats captured in the current run.
REQ-019 SHALL have port finished, output, 1, run-complete flag.

Function
REQ-020 SHALL implement the states IDLE, LOAD, ISSUE, GUARD, WAIT, CAPTURE and FINISH.
REQ-021 SHALL accept prog_we writes only in IDLE or FINISH; writes in all other states are ignored.
REQ-022 SHALL, on start in IDLE or FINISH, latch data_len and cmd_len, clear res_count, clear finished, and go to LOAD (or to ISSUE if data_len=0); start in any other state is ignored.
REQ-023 SHALL, in LOAD, drive data_valid=1 and data=dmem[ptr] for exactly data_len consecutive cycles with no gaps, ptr running 0..data_len-1, then drive data_valid=0.
REQ-024 SHALL, after LOAD, go to ISSUE if cmd_len>0, otherwise to FINISH.
REQ-025 SHALL, in ISSUE, wait for busy=0, then assert cmd_valid for exactly one cycle with cmd, index and value taken from cmem[cptr].
REQ-026 SHALL hold cmd, index and value stable during the cmd_valid cycle; their value while cmd_valid=0 is don't-care.
REQ-027 SHALL spend one GUARD cycle after the issue cycle, with busy ignored, then enter WAIT.
REQ-028 SHALL treat cmd values 4, 6 and 7 as write-back commands.
REQ-029 SHALL go from GUARD to CAPTURE when the issued command is a write-back command; later command entries are never issued.
REQ-030 SHALL, in WAIT, once busy=0, increment cptr and go to ISSUE if cptr+1<cmd_len, otherwise to FINISH.
REQ-031 SHALL, on every cycle with RAM_valid=1 in any state, write RAM_D into result memory at RAM_A and increment res_count, saturating at 256.
REQ-032 SHALL go from CAPTURE to FINISH on the first cycle with done=1, and still capture a RAM_valid beat present in that same cycle.
REQ-033 SHALL, in FINISH, hold finished=1 until the next accepted start.
REQ-034 SHALL, when busy=0 occurs in the same cycle as the move into ISSUE, issue the command in that cycle with no extra latency.

Reset
REQ-035 SHALL, on rst, asynchronously enter IDLE and clear data_valid, cmd_valid, finished, res_count, ptr, cptr and the latched lengths to 0.
REQ-036 SHALL preserve program-memory and result-memory contents across reset.
REQ-037 SHALL, on reset during any run, abandon the run and issue no further commands or data until the next start.

Verification
REQ-038 Bench SHALL check: data_len=4, dmem={5,9,2,7}, cmd_len=0, start -> data_valid high for exactly 4 cycles with data 5,9,2,7, then finished=1.
REQ-039 Bench SHALL check: cmds {0,0,0} then {4,0,0}, with busy modelled as 3 cycles after each cmd_valid -> exactly two cmd_valid pulses, the second no earlier than the first cycle with busy=0 after the guard cycle.
REQ-040 Bench SHALL check: write-back responder sends RAM_A=0..3 with RAM_D={9,7,5,2} and raises done together with the last beat -> res_count=4, rd_addr 0..3 reads 9,7,5,2, finished=1.
REQ-041 Bench SHALL check: cmd list {4,0,0},{1,0,0} -> only the cmd 4 entry is issued.
REQ-042 Bench SHALL check: rst asserted mid-LOAD -> data_valid=0 immediately; prog_we then writes dmem successfully; a new start streams from ptr 0.
REQ-043 Bench SHALL check: prog_we during WAIT -> command memory unchanged.
